// File: rtl/nios_system_key_in_pkg.sv
// nios_system_key_in_pkg: register addresses and edge-type encodings for the key input PIO
package nios_system_key_in_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/nios_system_key_in_if.sv
// nios_system_key_in_if: Avalon-MM slave bus plus interrupt line
interface nios_system_key_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  modport master (output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/nios_system_key_in_debounce.sv
// nios_system_key_in_debounce: one-bit two-flop synchronizer followed by a stability-count debouncer
module nios_system_key_in_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IN_RESET        = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_in,
  output logic o_db
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic          r_sync1, r_sync2, r_db;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= IN_RESET;
      r_sync2 <= IN_RESET;
      r_db    <= IN_RESET;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) r_cnt <= '0;
      else if (r_cnt == CMAX) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + CW'(1);
    end
  end
  assign o_db = r_db;
endmodule

// File: rtl/nios_system_key_in.sv
// nios_system_key_in: debounced key input PIO with edge capture and maskable level interrupt
module nios_system_key_in
  import nios_system_key_in_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IN_RESET        = '0
) (
  input logic                 clk,
  input logic                 reset_n,
  nios_system_key_in_if.slave bus,
  input logic [WIDTH-1:0]     in_port
);
  logic [WIDTH-1:0] w_db, w_rise, w_fall, w_edge, w_clr;
  logic [WIDTH-1:0] r_db_d, r_mask, r_edge;
  logic [31:0]      r_rdata, w_rdata;
  logic             w_wr, w_unused;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_system_key_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IN_RESET       (IN_RESET[i])
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .i_in   (in_port[i]),
      .o_db   (w_db[i])
    );
  end
  assign w_unused = &{1'b0, bus.writedata};
  assign w_wr     = bus.chipselect && !bus.write_n;
  assign w_rise   = w_db & ~r_db_d;
  assign w_fall   = ~w_db & r_db_d;
  assign w_edge   = EDGE_TYPE == EDGE_RISE ? w_rise : EDGE_TYPE == EDGE_FALL ? w_fall : w_rise | w_fall;
  assign w_clr    = (w_wr && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
  assign w_rdata  = bus.address == ADDR_DATA ? 32'(w_db) :
                    bus.address == ADDR_MASK ? 32'(r_mask) :
                    bus.address == ADDR_EDGE ? 32'(r_edge) : '0;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_db_d  <= IN_RESET;
      r_mask  <= '0;
      r_edge  <= '0;
      r_rdata <= '0;
    end else begin
      r_db_d  <= w_db;
      r_edge  <= (r_edge & ~w_clr) | w_edge;
      r_rdata <= w_rdata;
      if (w_wr && bus.address == ADDR_MASK) r_mask <= bus.writedata[WIDTH-1:0];
    end
  end
  assign bus.readdata = r_rdata;
  assign bus.irq      = |(r_edge & r_mask);
endmodule

// File: tb/tb_nios_system_key_in.sv
// tb_nios_system_key_in: directed stimulus checked every cycle against a sliding-window debounce model
module tb_nios_system_key_in;
  localparam int W = 4;
  localparam int D = 4;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = 4'hF;
  int           n_vec = 0;
  int           n_err = 0;
  nios_system_key_in_if bus ();
  nios_system_key_in #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1), .IN_RESET(4'hF)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .in_port(in_port)
  );
  always #5 clk = ~clk;
  // model: a bit's debounced value flips once its last D synchronized samples all disagree with it
  logic [W-1:0] h [0:D];
  logic [W-1:0] m_db, m_dbd, m_cap, m_mask, stable, fall, clr;
  logic [31:0]  m_rd;
  logic         m_irq;
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int j = 0; j <= D; j++) h[j] = 4'hF;
      m_db = 4'hF; m_dbd = 4'hF; m_cap = '0; m_mask = '0; m_rd = '0;
    end else begin
      case (bus.address)
        2'd0: m_rd = {28'b0, m_db};
        2'd2: m_rd = {28'b0, m_mask};
        2'd3: m_rd = {28'b0, m_cap};
        default: m_rd = '0;
      endcase
      stable = '1;
      for (int j = 1; j <= D; j++) stable &= h[j] ^ m_db;
      fall = ~m_db & m_dbd;
      clr = (bus.chipselect && !bus.write_n && bus.address == 2'd3) ? bus.writedata[W-1:0] : '0;
      if (bus.chipselect && !bus.write_n && bus.address == 2'd2) m_mask = bus.writedata[W-1:0];
      m_cap = (m_cap & ~clr) | fall;
      m_dbd = m_db;
      m_db = m_db ^ stable;
      for (int j = D; j >= 1; j--) h[j] = h[j-1];
      h[0] = in_port;
    end
    m_irq = |(m_cap & m_mask);
  end
  always @(negedge clk) begin
    n_vec++;
    if (bus.readdata !== m_rd) begin
      n_err++;
      $display("FAIL model_readdata t=%0t got %h want %h", $time, bus.readdata, m_rd);
    end
    n_vec++;
    if (bus.irq !== m_irq) begin
      n_err++;
      $display("FAIL model_irq t=%0t got %b want %b", $time, bus.irq, m_irq);
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    bus.address = a; bus.chipselect = 1'b1;
    @(negedge clk);
    bus.chipselect = 1'b0;
    chk(nm, bus.readdata, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    tick(3);
    reset_n = 1'b1;
    chk("reset_readdata", bus.readdata, 32'h0);
    chk("reset_irq", 32'(bus.irq), 32'h0);
    rd(2'd0, 32'h0000000F, "reset_data");
    rd(2'd3, 32'h0, "reset_edge");
    wr(2'd2, 32'h1);
    in_port = 4'hE;
    tick(6);
    chk("fall_irq_early", 32'(bus.irq), 32'h0);
    tick(1);
    chk("fall_irq", 32'(bus.irq), 32'h1);
    rd(2'd3, 32'h1, "fall_edge");
    rd(2'd0, 32'hE, "fall_data");
    in_port = 4'hF;
    tick(10);
    wr(2'd3, 32'hF);
    chk("clear_irq", 32'(bus.irq), 32'h0);
    in_port = 4'hD;
    tick(3);
    in_port = 4'hF;
    tick(10);
    rd(2'd0, 32'hF, "glitch_data");
    rd(2'd3, 32'h0, "glitch_edge");
    in_port = 4'hB;
    tick(10);
    rd(2'd3, 32'h4, "masked_edge");
    chk("masked_irq", 32'(bus.irq), 32'h0);
    wr(2'd2, 32'h4);
    chk("unmasked_irq", 32'(bus.irq), 32'h1);
    rd(2'd2, 32'h4, "mask_read");
    wr(2'd3, 32'hF);
    in_port = 4'hF;
    tick(10);
    wr(2'd2, 32'h1);
    in_port = 4'hE;
    tick(6);
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h1, "set_wins_edge");
    chk("set_wins_irq", 32'(bus.irq), 32'h1);
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h0, "clear_all_edge");
    chk("clear_all_irq", 32'(bus.irq), 32'h0);
    in_port = 4'hF;
    tick(10);
    in_port = 4'h7;
    tick(4);
    reset_n = 1'b0;
    in_port = 4'hF;
    tick(2);
    reset_n = 1'b1;
    chk("rst2_readdata", bus.readdata, 32'h0);
    tick(10);
    rd(2'd0, 32'hF, "rst2_data");
    rd(2'd3, 32'h0, "rst2_edge");
    chk("rst2_irq", 32'(bus.irq), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
